// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : muldiv_pkg
//  Purpose : Shared types and constants for the mips_cpu_muldiv unit:
//            request opcodes, FSM state encoding, divide-by-zero LO value,
//            and an opcode-signedness helper.
//  Ports   : (package, none)
//  Rev     : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } muldiv_state_t;

  // LO after a divide by zero; sliced to WIDTH at the point of use.
  localparam logic [63:0] DIV0_LO = {64{1'b1}};

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
//  Module  : muldiv_div_step
//  Purpose : One combinational restoring-division step. Shifts the next
//            dividend bit (MSB of the quotient register) into the partial
//            remainder, trial-subtracts the divisor and shifts the resulting
//            quotient bit into the quotient register.
//  Ports   : i_rem  [WIDTH] partial remainder in
//            i_quo  [WIDTH] quotient / remaining dividend bits in
//            i_div  [WIDTH] divisor (magnitude)
//            o_rem  [WIDTH] next partial remainder
//            o_quo  [WIDTH] next quotient register
//  Rev     : 1.0  initial release
// ============================================================================
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  assign w_shift  = {i_rem, i_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, i_div};
  // With a non-zero divisor the remainder stays below the divisor, so the
  // trial difference fits in WIDTH bits and bit WIDTH is a pure borrow flag.
  // A zero divisor breaks that invariant; the top level overrides that result.
  assign w_borrow = w_diff[WIDTH];

  assign o_rem = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule
`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module  : mips_cpu_muldiv
//  Purpose : Iterative multiply/divide unit owning the HI/LO registers.
//            Executes MULT, MULTU, DIV, DIVU (WIDTH radix-2 steps plus a
//            sign-fixup cycle) and MTHI/MTLO (written on the accept edge).
//  Config  : MULDIV_FAST_MUL_EN - when defined, MULT/MULTU use a single
//            combinational 2*WIDTH multiply and skip the iterative phase.
//  Ports   : clk       clock, rising edge
//            reset_n   asynchronous active-low reset
//            in_valid  request present
//            in_ready  unit idle, request can be taken
//            op        muldiv_op_t opcode
//            a, b      rs / rt operands [WIDTH]
//            flush     abort in-flight operation, block acceptance
//            busy      operation in flight
//            done      one-cycle completion pulse (registered)
//            hi, lo    architectural HI / LO [WIDTH]
//  Rev     : 1.0  initial release
// ============================================================================
module mips_cpu_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t      r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  // Shared accumulator: multiply {partial product, remaining multiplier},
  // divide {partial remainder, quotient/remaining dividend}.
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_mag;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_a;        // raw rs, needed for the divide-by-zero HI
  logic               r_neg_q;    // negate product / quotient
  logic               r_neg_r;    // negate remainder (dividend sign)
  logic               r_div0;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_is_mul_op, w_is_div_op;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;

  assign w_accept    = in_valid && in_ready && !flush;
  assign w_is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_a_neg     = is_signed_op(op) && a[WIDTH-1];
  assign w_b_neg     = is_signed_op(op) && b[WIDTH-1];
  // Most-negative values map to 2^(WIDTH-1), which is still correct unsigned.
  assign w_mag_a     = w_a_neg ? -a : a;
  assign w_mag_b     = w_b_neg ? -b : b;

  // Shift-add multiply step: add multiplicand when the current multiplier
  // LSB is set, then shift the whole accumulator right by one.
  assign w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_mag} : '0);
  assign w_mul_nxt = {w_mul_sum, r_p[WIDTH-1:1]};

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_p[2*WIDTH-1:WIDTH]),
    .i_quo (r_p[WIDTH-1:0]),
    .i_div (r_mag),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  assign w_mul_res = r_neg_q ? -r_p : r_p;
  assign w_quo_fix = r_neg_q ? -r_p[WIDTH-1:0]       : r_p[WIDTH-1:0];
  assign w_rem_fix = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul_op) begin
`ifdef MULDIV_FAST_MUL_EN
          w_state_nxt = ST_FIXUP;
`else
          w_state_nxt = ST_MUL;
`endif
        end else if (w_accept && w_is_div_op) begin
          w_state_nxt = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush)              w_state_nxt = ST_IDLE;
        else if (r_cnt == '0)   w_state_nxt = ST_FIXUP;
      end
      ST_FIXUP: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_p      <= '0;
      r_mag    <= '0;
      r_a      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= a;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (b == '0);
            r_is_div <= w_is_div_op;
            r_cnt    <= c_CNT_W'(WIDTH - 1);
            case (op)
              OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                r_p   <= w_fast_prod;
`else
                r_p   <= {{WIDTH{1'b0}}, w_mag_b};
`endif
                r_mag <= w_mag_a;
              end
              OP_DIV, OP_DIVU: begin
                r_p   <= {{WIDTH{1'b0}}, w_mag_a};
                r_mag <= w_mag_b;
              end
              OP_MTHI: begin
                r_hi   <= a;
                r_done <= 1'b1;
              end
              OP_MTLO: begin
                r_lo   <= a;
                r_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          r_p <= w_mul_nxt;
          if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_W'(1);
        end
        ST_DIV: begin
          r_p <= {w_rem_nxt, w_quo_nxt};
          if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_W'(1);
        end
        ST_FIXUP: begin
          if (!flush) begin
            r_done <= 1'b1;
            if (!r_is_div) begin
              {r_hi, r_lo} <= w_mul_res;
            end else if (r_div0) begin
              r_hi <= r_a;
              r_lo <= DIV0_LO[WIDTH-1:0];
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
